// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel programmable clock-enable / divided-clock generator.
//   Each channel owns a shadow {period, high} written from the config port,
//   and an active {period, high} used by its counter. The active copy only
//   changes at a period boundary (or while the channel is idle), so
//   reprogramming never produces a runt pulse.
//
// Optional feature macro: CLK_DIV_PHASE_SYNC_EN
//   When defined, adds the 'sync' input. A sync pulse restarts every enabled
//   channel at cnt=0 with its shadow configuration loaded, phase-aligning all
//   channels.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         per-channel run enable (level)
//   wr_en      configuration write strobe
//   wr_ch      channel addressed by the write
//   wr_period  new period in clk cycles (0 is rejected)
//   wr_high    new high time in clk cycles
//   sync       phase-realign strobe (CLK_DIV_PHASE_SYNC_EN only)
//   wr_err     one-cycle pulse after a rejected write
//   clk_out    divided clock per channel
//   tick       one-cycle strobe on the last cycle of each period

// One divider channel: shadow/active configuration, counter, registered outputs.
module clk_div_ch #(
    parameter int CNT_W      = 25,
    parameter int DEF_PERIOD = 20000000,
    parameter int DEF_HIGH   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             restart;

    always_comb begin
        sh_period_d  = sh_period_q;
        sh_high_d    = sh_high_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        cnt_d        = cnt_q + ONE;
        run_d        = en;

        if (wr) begin
            sh_period_d = wr_period;
            sh_high_d   = wr_high;
        end

        // A period starts fresh on enable rise, on sync, or at the natural wrap.
        // The active copy is loaded from the registered shadow, so a write on
        // the same edge only takes effect at the following boundary.
        restart = !run_q || sync || (cnt_q == act_period_q - ONE);

        if (!en || restart) begin
            cnt_d        = '0;
            act_period_d = sh_period_q;
            act_high_d   = sh_high_q;
        end

        // Outputs are derived from next-state values so they line up with cnt.
        clk_out_d = en && (cnt_d < act_high_d);
        tick_d    = en && (cnt_d == act_period_d - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period_q  <= RST_PERIOD;
            sh_high_q    <= RST_HIGH;
            act_period_q <= RST_PERIOD;
            act_high_q   <= RST_HIGH;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
endmodule

module clk_div_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 25,
    parameter int CH_W       = 2,
    parameter int DEF_PERIOD = 20000000,
    parameter int DEF_HIGH   = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_period,
    input  logic [CNT_W-1:0]  wr_high,
`ifdef CLK_DIV_PHASE_SYNC_EN
    input  logic              sync,
`endif
    output logic              wr_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    logic              wr_ok;
    logic              wr_err_q, wr_err_d;
    logic [NUM_CH-1:0] ch_wr;
    logic              sync_i;

`ifdef CLK_DIV_PHASE_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    always_comb begin
        wr_ok    = wr_en && (int'(wr_ch) < NUM_CH) && (wr_period != '0);
        wr_err_d = wr_en && !wr_ok;
        ch_wr    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = wr_ok && (int'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .sync      (sync_i),
            .wr        (ch_wr[i]),
            .wr_period (wr_period),
            .wr_high   (wr_high),
            .clk_out   (clk_out[i]),
            .tick      (tick[i])
        );
    end
endmodule
